tdma_slot_scheduler: RTL and testbench



---
 rtl/tdma_slot_scheduler.sv | 125 ++++++++++++
 tb/tb_tdma_slot_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tdma_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tdma_slot_scheduler
// Description : Shares one TDMA send port among NUM_REQ requesters, one fixed
//               slot per requester per round, each with a 1-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tdma_slot_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int SLOT_CYCLES = 16,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [ADDR_W-1:0]          tdma_send_addr,
    output logic [DATA_W-1:0]          tdma_send_data,
    output logic                       tdma_send_valid,
    output logic [$clog2(NUM_REQ)-1:0] slot_idx,
    output logic                       slot_start
);

    localparam int               c_cnt_w    = $clog2(SLOT_CYCLES);
    localparam int               c_idx_w    = $clog2(NUM_REQ);
    localparam logic [c_cnt_w-1:0] c_last_cyc = c_cnt_w'(SLOT_CYCLES - 1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);

    logic [c_cnt_w-1:0] r_cyc_cnt;
    logic [c_idx_w-1:0] r_slot_idx;
    logic               r_slot_start;
    logic [NUM_REQ-1:0] r_full;
    logic [ADDR_W-1:0]  r_buf_addr [NUM_REQ];
    logic [DATA_W-1:0]  r_buf_data [NUM_REQ];
    logic [ADDR_W-1:0]  r_send_addr;
    logic [DATA_W-1:0]  r_send_data;
    logic               r_send_valid;

    logic               w_boundary;
    logic [c_idx_w-1:0] w_next_idx;
    logic [NUM_REQ-1:0] w_load;
    logic               w_load_any;

    // w_load is the one-hot buffer drained at this boundary edge, if any.
    always_comb begin
        w_boundary = (r_cyc_cnt == c_last_cyc);
        w_next_idx = (r_slot_idx == c_last_idx) ? '0 : r_slot_idx + c_idx_w'(1);
        w_load     = '0;
        if (w_boundary) begin
            w_load = r_full & (NUM_REQ'(1) << w_next_idx);
        end
        w_load_any = |w_load;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_cyc_cnt    <= c_last_cyc;
            r_slot_idx   <= c_last_idx;
            r_slot_start <= 1'b0;
        end else begin
            r_slot_start <= w_boundary;
            if (w_boundary) begin
                r_cyc_cnt  <= '0;
                r_slot_idx <= w_next_idx;
            end else begin
                r_cyc_cnt <= r_cyc_cnt + c_cnt_w'(1);
            end
        end
    end

    // Load and accept are mutually exclusive per buffer: load needs it full,
    // accept needs it empty, so an accept on its own boundary waits a round.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_full <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_load[i]) begin
                    r_full[i] <= 1'b0;
                end else if (req_valid[i] && !r_full[i]) begin
                    r_full[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !r_full[i]) begin
                r_buf_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                r_buf_data[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_send_addr  <= '0;
            r_send_data  <= '0;
            r_send_valid <= 1'b0;
        end else if (w_boundary) begin
            if (w_load_any) begin
                r_send_addr  <= r_buf_addr[w_next_idx];
                r_send_data  <= r_buf_data[w_next_idx];
                r_send_valid <= 1'b1;
            end else begin
                r_send_addr  <= '0;
                r_send_data  <= '0;
                r_send_valid <= 1'b0;
            end
        end
    end

    assign req_ready       = ~r_full;
    assign tdma_send_addr  = r_send_addr;
    assign tdma_send_data  = r_send_data;
    assign tdma_send_valid = r_send_valid;
    assign slot_idx        = r_slot_idx;
    assign slot_start      = r_slot_start;

endmodule
`default_nettype wire

// File: tb/tb_tdma_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdma_slot_scheduler
// Description : Directed bench with a per-slot scoreboard for the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdma_slot_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_data = '0;
    logic [7:0]   send_addr;
    logic [31:0]  send_data;
    logic         send_valid;
    logic [1:0]   slot_idx;
    logic         slot_start;

    int checks = 0;
    int errors = 0;
    int tcyc   = -1;

    typedef struct {
        int          slot;
        logic [7:0]  a;
        logic [31:0] d;
    } sb_t;
    sb_t sb[$];

    tdma_slot_scheduler #(
        .NUM_REQ(4), .SLOT_CYCLES(16), .ADDR_W(8), .DATA_W(32)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .tdma_send_addr (send_addr),
        .tdma_send_data (send_data),
        .tdma_send_valid(send_valid),
        .slot_idx       (slot_idx),
        .slot_start     (slot_start)
    );

    always #5 clk = ~clk;

    // Absolute cycle number; 0 is the cycle right after the release edge.
    always @(posedge clk) tcyc <= rst_n ? tcyc + 1 : -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic at_cycle(input int c);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (tcyc == c) return;
        end
        chk("wait_timeout", 64'(tcyc), 64'(c));
    endtask

    task automatic push(input int slot, input logic [7:0] a, input logic [31:0] d);
        sb_t e;
        e.slot = slot;
        e.a    = a;
        e.d    = d;
        sb.push_back(e);
    endtask

    task automatic set_word(input int i, input logic [7:0] a, input logic [31:0] d);
        req_addr[i*8 +: 8]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic chk_reset_state();
        chk("rst_valid", send_valid, 1'b0);
        chk("rst_addr", send_addr, 8'h00);
        chk("rst_data", send_data, 32'h0);
        chk("rst_slot_start", slot_start, 1'b0);
        chk("rst_ready", req_ready, 4'hf);
        chk("rst_slot_idx", slot_idx, 2'd3);
    endtask

    // Each slot's expected output is fixed at its first cycle and must hold.
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic        m_valid;
    logic [1:0]  m_idx;
    sb_t         m_e;
    always @(negedge clk) begin
        if (rst_n && tcyc >= 0) begin
            m_idx = 2'((tcyc / 16) % 4);
            if (tcyc % 16 == 0) begin
                m_valid = 1'b0;
                m_addr  = '0;
                m_data  = '0;
                if (sb.size() > 0 && sb[0].slot == tcyc / 16) begin
                    m_e     = sb.pop_front();
                    m_valid = 1'b1;
                    m_addr  = m_e.a;
                    m_data  = m_e.d;
                end
            end
            chk("slot_start", slot_start, (tcyc % 16 == 0));
            chk("slot_idx", slot_idx, m_idx);
            chk("send_valid", send_valid, m_valid);
            chk("send_addr", send_addr, m_addr);
            chk("send_data", send_data, m_data);
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;

        at_cycle(1);
        chk("idle_ready", req_ready, 4'hf);

        // Single word from requester 2 during slot 0 of round 1.
        at_cycle(66);
        set_word(2, 8'h2A, 32'hDEADBEEF);
        req_valid[2] = 1'b1;
        push(6, 8'h2A, 32'hDEADBEEF);
        at_cycle(67);
        req_valid[2] = 1'b0;
        chk("single_ready_low", req_ready[2], 1'b0);
        at_cycle(95);
        chk("single_ready_before_load", req_ready[2], 1'b0);
        at_cycle(97);
        chk("single_ready_freed", req_ready[2], 1'b1);

        // Requester 1 holds valid across a full buffer.
        at_cycle(130);
        set_word(1, 8'h11, 32'h1);
        req_valid[1] = 1'b1;
        push(9, 8'h11, 32'h1);
        at_cycle(131);
        set_word(1, 8'h22, 32'h2);
        chk("full_ready_low", req_ready[1], 1'b0);
        at_cycle(143);
        chk("full_still_held", req_ready[1], 1'b0);
        at_cycle(144);
        chk("full_freed", req_ready[1], 1'b1);
        push(13, 8'h22, 32'h2);
        at_cycle(145);
        req_valid[1] = 1'b0;
        chk("full_recaptured", req_ready[1], 1'b0);

        // Requester 3 accepted on its own boundary edge: slot 15 idle, sent in 19.
        at_cycle(239);
        set_word(3, 8'h33, 32'h33333333);
        req_valid[3] = 1'b1;
        push(19, 8'h33, 32'h33333333);
        at_cycle(240);
        req_valid[3] = 1'b0;
        chk("same_edge_ready", req_ready[3], 1'b0);

        // All requesters at once, just before a round begins.
        at_cycle(318);
        for (int i = 0; i < 4; i++) begin
            set_word(i, 8'hA0 + 8'(i), 32'hC0DE0000 + 32'(i));
            push(20 + i, 8'hA0 + 8'(i), 32'hC0DE0000 + 32'(i));
        end
        req_valid = 4'hf;
        at_cycle(319);
        req_valid = 4'h0;
        chk("all_ready_low", req_ready, 4'h0);

        // Fill buffers 1 and 2, then reset in slot 0 cycle 5.
        at_cycle(386);
        set_word(1, 8'h5A, 32'h5A5A5A5A);
        set_word(2, 8'hA5, 32'hA5A5A5A5);
        req_valid = 4'b0110;
        at_cycle(387);
        req_valid = 4'h0;
        chk("pre_reset_ready", req_ready, 4'b1001);
        chk("sb_drained", sb.size(), 0);
        at_cycle(389);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        at_cycle(0);
        chk("post_reset_slot_idx", slot_idx, 2'd0);
        chk("post_reset_ready", req_ready, 4'hf);
        at_cycle(80);
        chk("post_reset_ready_late", req_ready, 4'hf);
        chk("sb_empty_end", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
